// File: rtl/ring_fifo_wr_arbiter.sv
// ring_fifo_wr_arbiter
//   Round-robin write arbiter in front of a ring FIFO. A requester wins one
//   grant and may push up to BURST words before the grant is released. The
//   arbiter always spends one IDLE cycle choosing the next owner.
//
//   Ports
//     clk          single clock, rising edge
//     reset        asynchronous, active low
//     req_valid    per-requester word present
//     req_data     packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready    per-requester word accepted this cycle (owner only)
//     fifo_write   write strobe to the ring FIFO
//     fifo_datain  word to the ring FIFO (zero outside GRANT)
//     fifo_full    ring FIFO full flag
//     grant_id     current owner; holds its last value in IDLE
//     busy         1 while in GRANT
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no owner; pick next requester after last_owner, no writes
//   S_GRANT | owner pushes words while valid and FIFO not full, <= BURST
module ring_fifo_wr_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          fifo_write,
   output logic [DATA_WIDTH-1:0]         fifo_datain,
   input  logic                          fifo_full,
   output logic [$clog2(N_REQ)-1:0]      grant_id,
   output logic                          busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(BURST + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
   localparam logic [IW-1:0] LAST_REQ  = IW'(N_REQ - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [IW-1:0]     last_owner_q, last_owner_d;
   logic [CW-1:0]     beat_cnt_q, beat_cnt_d;

   logic                  owner_valid;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  pick_found;
   logic [IW-1:0]         pick_idx;

   always_comb begin
      owner_valid = 1'b0;
      owner_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == IW'(i)) begin
            owner_valid = req_valid[i];
            owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Rotating priority: the requester just after last_owner is searched first,
   // so the previous owner is considered last.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!pick_found && last_owner_q == IW'(j) && req_valid[(j + off) % N_REQ]) begin
               pick_found = 1'b1;
               pick_idx   = IW'((j + off) % N_REQ);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         owner_q      <= '0;
         last_owner_q <= LAST_REQ;
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               owner_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = S_GRANT;
            end
         end
         S_GRANT: begin
            // beat_cnt tops out at BURST, which fits in CW bits, so no wrap.
            if (fifo_write) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (!owner_valid || (fifo_write && beat_cnt_q == LAST_BEAT)) begin
               state_d      = S_IDLE;
               last_owner_d = owner_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready   = '0;
      fifo_write  = 1'b0;
      fifo_datain = '0;
      busy        = 1'b0;
      if (state_q == S_GRANT) begin
         busy        = 1'b1;
         fifo_write  = owner_valid & ~fifo_full;
         fifo_datain = owner_data;
         for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IW'(i)) begin
               req_ready[i] = fifo_write;
            end
         end
      end
   end

   assign grant_id = owner_q;

endmodule

// File: doc/ring_fifo_wr_arbiter.md
RING_FIFO_WR_ARBITER -- requirements
Module: ring_fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8: data word width, equal to the ring FIFO data width.
REQ-003 Parameter BURST, default 4: maximum beats accepted per grant (1..16).
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset; 0 = reset asserted.
REQ-006 Port req_valid  input  N_REQ: bit i = requester i presents a word.
REQ-007 Port req_data  input  N_REQ*DATA_WIDTH: requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_ready  output  N_REQ: bit i = word of requester i accepted this cycle.
REQ-009 Port fifo_write  output  1: write strobe to the ring FIFO.
REQ-010 Port fifo_datain  output  DATA_WIDTH: word to the ring FIFO.
REQ-011 Port fifo_full  input  1: ring FIFO full flag.
REQ-012 Port grant_id  output  $clog2(N_REQ): index of the current owner (valid while busy=1).
REQ-013 Port busy  output  1: 1 while state is GRANT.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-015 In IDLE with any req_valid bit set, the block SHALL select the first set bit searching upward from (last_owner+1) mod N_REQ, wrapping, register it as owner, clear beat_cnt, and enter GRANT on the next edge.
REQ-016 In IDLE, req_ready and fifo_write SHALL be 0 (one arbitration cycle per grant).
REQ-017 In GRANT, fifo_write SHALL equal req_valid[owner] AND NOT fifo_full, combinationally.
REQ-018 In GRANT, req_ready[owner] SHALL equal fifo_write; all other req_ready bits SHALL be 0.
REQ-019 fifo_datain SHALL equal the owner's req_data slice in GRANT and all zeros in IDLE.
REQ-020 Each cycle with fifo_write=1 SHALL count one beat; beat_cnt SHALL be $clog2(BURST+1) bits wide and never wrap.
REQ-021 GRANT SHALL return to IDLE when a beat is accepted with beat_cnt = BURST-1, or when req_valid[owner] = 0.
REQ-022 On leaving GRANT, last_owner SHALL be loaded with owner.
REQ-023 While fifo_full = 1 and req_valid[owner] = 1, the block SHALL stay in GRANT with beat_cnt frozen and no write.
REQ-024 A requester not granted SHALL see req_ready = 0 and SHALL NOT be dropped; it competes at the next IDLE.
REQ-025 A word SHALL be written to the FIFO if and only if exactly one req_ready bit is 1 in the same cycle.
REQ-026 grant_id SHALL equal owner in GRANT and hold its last value in IDLE.

Reset
REQ-027 While reset = 0, the block SHALL asynchronously force state=IDLE, owner=0, beat_cnt=0, and last_owner=N_REQ-1 (requester 0 wins first).
REQ-028 During reset, outputs SHALL be req_ready=0, fifo_write=0, fifo_datain=0, busy=0, grant_id=0.
REQ-029 Reset asserted mid-burst SHALL abort the grant; no write SHALL occur in the reset-release cycle.

Verification
REQ-030 After reset, req_valid=0001 held with data 0x11..0x16 and BURST=4 -> IDLE cycle, then 4 writes 0x11..0x14, then IDLE, then writes 0x15, 0x16.
REQ-031 req_valid=1111 held continuously, BURST=4 -> grant order 0,1,2,3,0, each grant exactly 4 writes separated by one idle cycle.
REQ-032 Owner 2 mid-burst with fifo_full=1 for 3 cycles -> fifo_write=0 and req_ready=0 for 3 cycles, busy=1, then the burst resumes and completes the remaining beats.
REQ-033 Owner 1 drops req_valid after 2 beats while req_valid[3]=1 -> return to IDLE, next grant to 3, beat count restarts at 0.
REQ-034 reset pulled low during beat 2 of owner 0 -> outputs zero immediately; after release with req_valid=0011, the first grant is requester 0.
REQ-035 With random valid/full stimulus, the bench checks every cycle: at most one req_ready bit set, and fifo_write = OR(req_ready).
